// File: rtl/detector_jogada.sv
// Button conditioner for the game datapath: two-flop synchronizer, press/release debounce FSM and one-hot move output.
// Optional feature: define DETECTOR_JOGADA_MULTI_REJ_EN to reject multi-button presses with an `invalida` pulse.
module detector_jogada #(
    parameter int DEBOUNCE = 20,
    parameter int N        = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       invalida,
    output logic       tem_jogada,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        FILTRA   = 2'd1,
        SOLTAR   = 2'd2,
        INVALIDO = 2'd3
    } estado_t;

    localparam logic [N-1:0] CNT_FIM = N'(DEBOUNCE - 1);

    estado_t      estado_reg, estado_next;
    logic [3:0]   sync1_reg, sync2_reg;
    logic [3:0]   cand_reg, cand_next;
    logic [N-1:0] cnt_reg, cnt_next;
    logic [3:0]   jogada_reg, jogada_next;
    logic         feita_reg, feita_next;
    logic         s_ativo;

    assign s_ativo = |sync2_reg;

`ifdef DETECTOR_JOGADA_MULTI_REJ_EN
    logic invalida_reg, invalida_next;
    logic cand_multi;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign cand_multi = |(cand_reg & (cand_reg - 4'd1));
    assign invalida   = invalida_reg;
`else
    logic [3:0] menor_bit;

    // Priority pick of the lowest-index pressed button (bit 0 wins).
    assign menor_bit[0] = cand_reg[0];
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_prio
            assign menor_bit[gi] = cand_reg[gi] & ~(|cand_reg[gi-1:0]);
        end
    endgenerate
    assign invalida = 1'b0;
`endif

    // State register, synchronizer and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            estado_reg   <= OCIOSO;
            cand_reg     <= '0;
            cnt_reg      <= '0;
            jogada_reg   <= '0;
            feita_reg    <= 1'b0;
`ifdef DETECTOR_JOGADA_MULTI_REJ_EN
            invalida_reg <= 1'b0;
`endif
        end else begin
            sync1_reg    <= botoes;
            sync2_reg    <= sync1_reg;
            estado_reg   <= estado_next;
            cand_reg     <= cand_next;
            cnt_reg      <= cnt_next;
            jogada_reg   <= jogada_next;
            feita_reg    <= feita_next;
`ifdef DETECTOR_JOGADA_MULTI_REJ_EN
            invalida_reg <= invalida_next;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        estado_next   = estado_reg;
        cand_next     = cand_reg;
        cnt_next      = cnt_reg;
        jogada_next   = jogada_reg;
        feita_next    = 1'b0;
`ifdef DETECTOR_JOGADA_MULTI_REJ_EN
        invalida_next = 1'b0;
`endif
        case (estado_reg)
            OCIOSO: begin
                if (s_ativo && habilita) begin
                    estado_next = FILTRA;
                    cand_next   = sync2_reg;
                    cnt_next    = '0;
                end
            end
            FILTRA: begin
                if (!habilita || !s_ativo) begin
                    estado_next = OCIOSO;
                end else if (sync2_reg != cand_reg) begin
                    // Button set changed mid-filter: restart on the new pattern.
                    cand_next = sync2_reg;
                    cnt_next  = '0;
                end else if (cnt_reg == CNT_FIM) begin
                    estado_next = SOLTAR;
                    cnt_next    = '0;
`ifdef DETECTOR_JOGADA_MULTI_REJ_EN
                    if (cand_multi) begin
                        invalida_next = 1'b1;
                    end else begin
                        jogada_next = cand_reg;
                        feita_next  = 1'b1;
                    end
`else
                    jogada_next = menor_bit;
                    feita_next  = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg + N'(1);
                end
            end
            SOLTAR: begin
                // Release tracking ignores habilita so a held button can never re-fire.
                if (s_ativo) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_FIM) begin
                    estado_next = OCIOSO;
                end else begin
                    cnt_next = cnt_reg + N'(1);
                end
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        jogada       = jogada_reg;
        jogada_feita = feita_reg;
        tem_jogada   = s_ativo;
        db_estado    = estado_reg;
    end

endmodule

// File: doc/detector_jogada.md
# detector_jogada

Input-conditioning stage placed directly upstream of the game datapath: it takes the four raw player buttons and produces one clean, debounced, one-hot move per physical press. Its outputs drive the datapath's `botoes`/`jogada_feita`/`tem_jogada` inputs. It runs on the same gated game clock (nominal 1 kHz) as the datapath and control unit.

## Interface

- `DEBOUNCE`, default 20: consecutive stable cycles required to accept a press or a release (20 ms at 1 kHz); legal range 2..2^N−1.
- `N`, default 5: width of the debounce counter.

Ports:

- `clock`  in  1  game clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; clears all state when 0.
- `habilita`  in  1  when 1, new presses may be accepted.
- `botoes`  in  4  raw, asynchronous button levels, active-high.
- `jogada`  out  4  registered one-hot code of the last accepted move.
- `jogada_feita`  out  1  one-cycle pulse when a move is accepted.
- `invalida`  out  1  one-cycle pulse when a multi-button press is rejected (macro-dependent).
- `tem_jogada`  out  1  level: OR of the synchronized buttons.
- `db_estado`  out  2  current FSM state code.

## Operation

- Synchronizer: two flops per bit, `s[3:0]`, reset to 0. `tem_jogada = |s`, combinational from `s`.
- Registers: state, `cand[3:0]`, `cnt[N-1:0]`, `jogada`. All reset to 0 and OCIOSO. Pulses are registered and reset to 0.
- OCIOSO (0):
  - If `s != 0` and `habilita` = 1: go to FILTRA with `cand <= s`, `cnt <= 0`.
  - Otherwise stay.
- FILTRA (1):
  - If `habilita` = 0 or `s == 0`: go to OCIOSO with no pulse.
  - Else if `s != cand`: `cand <= s`, `cnt <= 0`, stay. This restarts filtering.
  - Else if `cnt == DEBOUNCE-1`: accept `cand` and go to SOLTAR with `cnt <= 0`.
  - Else `cnt <= cnt+1`.
- Accept with `cand` one-hot: `jogada <= cand`, `jogada_feita` = 1 for one cycle.
- Accept with `cand` multi-bit: behaviour is set by Configuration.
- SOLTAR (2):
  - `habilita` is ignored; release is always tracked.
  - If `s != 0`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`: go to OCIOSO.
  - Else `cnt <= cnt+1`.
  - No new move is possible until a full stable release completes.
- `jogada` holds its value until the next accepted move or reset. It never reads 0 after the first move.
- Code 3 is unreachable. If entered, go to OCIOSO on the next edge.
- Reset mid-operation: immediate return to OCIOSO with all outputs 0. A button held through reset release is treated as a fresh press.

## Timing

- Raw to `s`: 2 edges.
- `s` to FILTRA: 1 edge.
- Accept: DEBOUNCE further edges.
- Latency: `jogada_feita` and the new `jogada` appear together after edge 3+DEBOUNCE, counted from the first edge that samples the stable raw press. For DEBOUNCE = 20 this is 23.
- A press or glitch shorter than DEBOUNCE+1 synchronized cycles produces no pulse.
- A release shorter than DEBOUNCE cycles inside SOLTAR is a bounce. No second pulse is produced.
- At most one `jogada_feita` or `invalida` pulse per press; the two are never asserted together.
- When the top level gates `clock` for pause, all state freezes, including counters.

## Configuration

- `DETECTOR_JOGADA_MULTI_REJ_EN` defined:
  - A multi-bit `cand` at acceptance produces a one-cycle `invalida` pulse.
  - `jogada` and `jogada_feita` are unchanged.
  - The FSM goes to SOLTAR.
- Not defined:
  - `invalida` is tied to 0.
  - A multi-bit `cand` is accepted as its lowest-index set bit (priority bit 0 > 3). `jogada` is that one-hot code and `jogada_feita` pulses.

## Test plan

- Reset low for 3 cycles, then high; hold `botoes` = 0 → all outputs 0, `db_estado` = 0.
- `habilita` = 1, `botoes` = 4'b0100 held 40 cycles, then released → exactly one `jogada_feita` at edge 23, `jogada` = 4'b0100; `db_estado` returns to 0 20 cycles after `s` clears.
- 10-cycle glitch on bit 0, then 0 → no pulse, `jogada` unchanged, FSM back in OCIOSO.
- Press bit 1 stable, then inside SOLTAR bounce 0/1 every 5 cycles for 30 cycles → single pulse only; OCIOSO reached 20 cycles after the final release.
- `botoes` = 4'b1010 held 30 cycles:
  - With macro: `invalida` pulses once, `jogada_feita` stays 0.
  - Without macro: `jogada` = 4'b0010 and `jogada_feita` pulses.
- Press held with `habilita` = 0 → no pulse. Raising `habilita` while still held → pulse DEBOUNCE+1 edges later. Asserting reset at cycle 10 of FILTRA → outputs 0 asynchronously, no pulse.
